// File: rtl/adma_dm_dst_axis.sv
// adma_dm_dst_axis: DMA destination side streaming write data out as AXI-Stream beats
module adma_dm_dst_axis #(
  parameter int DMA_CHN_NUM      = 4,
  parameter int ATX_DST_DATA_W   = 256,
  parameter int ATX_DST_BYTE_AMT = ATX_DST_DATA_W / 8,
  parameter int DST_TDEST_W      = 2,
  parameter int MST_ID_W         = 5,
  parameter int ATX_LEN_W        = 8,
  parameter int ATX_NUM_OSTD     = DMA_CHN_NUM
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [MST_ID_W-1:0]         atx_awid,
  input  logic [ATX_LEN_W-1:0]        atx_awlen,
  input  logic [DST_TDEST_W-1:0]      atx_tdest,
  input  logic                        atx_vld,
  output logic                        atx_rdy,
  input  logic [ATX_DST_DATA_W-1:0]   atx_wdata,
  input  logic                        atx_wdata_vld,
  output logic                        atx_wdata_rdy,
  input  logic [MST_ID_W-1:0]         atx_id [0:DMA_CHN_NUM-1],
  output logic [DMA_CHN_NUM-1:0]      atx_done,
  output logic [DMA_CHN_NUM-1:0]      atx_dst_err,
  output logic [MST_ID_W-1:0]         m_tid_o,
  output logic [DST_TDEST_W-1:0]      m_tdest_o,
  output logic [ATX_DST_DATA_W-1:0]   m_tdata_o,
  output logic [ATX_DST_BYTE_AMT-1:0] m_tkeep_o,
  output logic [ATX_DST_BYTE_AMT-1:0] m_tstrb_o,
  output logic                        m_tlast_o,
  output logic                        m_tvalid_o,
  input  logic                        m_tready_i
);
  localparam int PW = (ATX_NUM_OSTD > 1) ? $clog2(ATX_NUM_OSTD) : 1;
  typedef struct packed {
    logic [MST_ID_W-1:0]    id;
    logic [ATX_LEN_W-1:0]   len;
    logic [DST_TDEST_W-1:0] dest;
  } info_t;
  info_t                       fifo_q [ATX_NUM_OSTD];
  info_t                       head;
  logic [PW:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ATX_LEN_W-1:0]        cnt_q, cnt_d;
  logic [ATX_DST_DATA_W-1:0]   tdata_q, tdata_d;
  logic [MST_ID_W-1:0]         tid_q, tid_d;
  logic [DST_TDEST_W-1:0]      tdest_q, tdest_d;
  logic [ATX_DST_BYTE_AMT-1:0] keep_q, keep_d;
  logic                        tlast_q, tlast_d, tvalid_q, tvalid_d;
  logic [DMA_CHN_NUM-1:0]      done_q, done_d;
  logic                        empty, full, push, wd_hs, last_beat, out_hs;
  assign head          = fifo_q[rd_ptr_q[PW-1:0]];
  assign empty         = wr_ptr_q == rd_ptr_q;
  assign full          = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign atx_rdy       = aresetn && !full;
  assign atx_wdata_rdy = !empty && (!tvalid_q || m_tready_i);
  assign push          = atx_vld && atx_rdy;
  assign wd_hs         = atx_wdata_vld && atx_wdata_rdy;
  assign last_beat     = cnt_q == head.len;
  assign out_hs        = tvalid_q && m_tready_i;
  assign m_tid_o       = tid_q;
  assign m_tdest_o     = tdest_q;
  assign m_tdata_o     = tdata_q;
  assign m_tkeep_o     = keep_q;
  assign m_tstrb_o     = keep_q;
  assign m_tlast_o     = tlast_q;
  assign m_tvalid_o    = tvalid_q;
  assign atx_done      = done_q;
  assign atx_dst_err   = '0;
  // Next state: FIFO pointers, beat counter, output beat register and completion pulses
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;
    rd_ptr_d = (wd_hs && last_beat) ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;
    cnt_d    = wd_hs ? (last_beat ? '0 : cnt_q + ATX_LEN_W'(1)) : cnt_q;
    tvalid_d = wd_hs || (tvalid_q && !m_tready_i);
    tdata_d  = wd_hs ? atx_wdata : tdata_q;
    tid_d    = wd_hs ? head.id : tid_q;
    tdest_d  = wd_hs ? head.dest : tdest_q;
    keep_d   = wd_hs ? '1 : keep_q;
    tlast_d  = wd_hs ? last_beat : tlast_q;
    done_d   = '0;
    for (int c = 0; c < DMA_CHN_NUM; c++)
      done_d[c] = out_hs && tlast_q && (tid_q == atx_id[c]);
  end
  // Transaction-info FIFO storage, written on each accepted push
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < ATX_NUM_OSTD; i++) fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q[PW-1:0]] <= '{id: atx_awid, len: atx_awlen, dest: atx_tdest};
    end
  end
  // Control and output register state
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tid_q    <= '0;
      tdest_q  <= '0;
      keep_q   <= '0;
      tlast_q  <= 1'b0;
      done_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tid_q    <= tid_d;
      tdest_q  <= tdest_d;
      keep_q   <= keep_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_adma_dm_dst_axis.sv
// tb_adma_dm_dst_axis: directed and randomized checks against a queue-based stream model
module tb_adma_dm_dst_axis;
  localparam int N = 4, W = 256, B = 32, TW = 2, IW = 5, LW = 8, OST = 4;
  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [IW-1:0] atx_awid = '0;
  logic [LW-1:0] atx_awlen = '0;
  logic [TW-1:0] atx_tdest = '0;
  logic          atx_vld = 1'b0, atx_rdy;
  logic [W-1:0]  atx_wdata = '0;
  logic          atx_wdata_vld = 1'b0, atx_wdata_rdy;
  logic [IW-1:0] atx_id [0:N-1];
  logic [N-1:0]  atx_done, atx_dst_err;
  logic [IW-1:0] m_tid_o;
  logic [TW-1:0] m_tdest_o;
  logic [W-1:0]  m_tdata_o;
  logic [B-1:0]  m_tkeep_o, m_tstrb_o;
  logic          m_tlast_o, m_tvalid_o;
  logic          m_tready_i = 1'b0;
  typedef struct {
    logic [W-1:0] data;
    int           id;
    int           dest;
    bit           last;
  } beat_t;
  int           mq_id[$], mq_len[$], mq_dest[$];
  int           mbeat = 0;
  beat_t        exp_q[$];
  int           oc[$];
  logic [N-1:0] exp_done = '0, exp_done_nx;
  int           checks = 0, errors = 0, cyc = 0, done_pulses = 0;
  bit           rand_ready = 0, push_seen, wd_seen, out_seen;
  logic [W-1:0] hold;

  adma_dm_dst_axis dut (
    .aclk(aclk), .aresetn(aresetn),
    .atx_awid(atx_awid), .atx_awlen(atx_awlen), .atx_tdest(atx_tdest),
    .atx_vld(atx_vld), .atx_rdy(atx_rdy),
    .atx_wdata(atx_wdata), .atx_wdata_vld(atx_wdata_vld), .atx_wdata_rdy(atx_wdata_rdy),
    .atx_id(atx_id), .atx_done(atx_done), .atx_dst_err(atx_dst_err),
    .m_tid_o(m_tid_o), .m_tdest_o(m_tdest_o), .m_tdata_o(m_tdata_o),
    .m_tkeep_o(m_tkeep_o), .m_tstrb_o(m_tstrb_o), .m_tlast_o(m_tlast_o),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i)
  );

  always #5 aclk = ~aclk;

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    bit    mrdy, mwrdy;
    beat_t b;
    if (rand_ready) m_tready_i = 1'($urandom_range(0, 1));
    @(negedge aclk);
    mrdy  = aresetn && (mq_id.size() < OST);
    mwrdy = (mq_id.size() > 0) && (exp_q.size() == 0 || m_tready_i);
    chk("tvalid", m_tvalid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("tdata", m_tdata_o, exp_q[0].data);
      chk("tid", m_tid_o, exp_q[0].id);
      chk("tdest", m_tdest_o, exp_q[0].dest);
      chk("tlast", m_tlast_o, exp_q[0].last);
      chk("tkeep", m_tkeep_o, {B{1'b1}});
      chk("tstrb", m_tstrb_o, {B{1'b1}});
    end
    chk("atx_rdy", atx_rdy, mrdy);
    chk("wdata_rdy", atx_wdata_rdy, mwrdy);
    chk("done", atx_done, exp_done);
    chk("dst_err", atx_dst_err, 0);
    done_pulses += $countones(atx_done);
    push_seen   = atx_vld && mrdy;
    wd_seen     = atx_wdata_vld && mwrdy;
    out_seen    = (exp_q.size() != 0) && m_tready_i;
    exp_done_nx = '0;
    if (out_seen) begin
      b = exp_q.pop_front();
      oc.push_back(cyc);
      if (b.last)
        for (int c = 0; c < N; c++) if (atx_id[c] == b.id) exp_done_nx[c] = 1'b1;
    end
    if (wd_seen) begin
      b.data = atx_wdata;
      b.id   = mq_id[0];
      b.dest = mq_dest[0];
      b.last = (mbeat == mq_len[0]);
      exp_q.push_back(b);
      if (b.last) begin
        void'(mq_id.pop_front());
        void'(mq_len.pop_front());
        void'(mq_dest.pop_front());
        mbeat = 0;
      end else mbeat++;
    end
    if (push_seen) begin
      mq_id.push_back(int'(atx_awid));
      mq_len.push_back(int'(atx_awlen));
      mq_dest.push_back(int'(atx_tdest));
    end
    @(posedge aclk);
    exp_done = exp_done_nx;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    atx_vld = 1'b0;
    atx_wdata_vld = 1'b0;
    mq_id.delete();
    mq_len.delete();
    mq_dest.delete();
    exp_q.delete();
    mbeat = 0;
    exp_done = '0;
    #1;
    chk("rst_tvalid", m_tvalid_o, 0);
    chk("rst_tlast", m_tlast_o, 0);
    chk("rst_tdata", m_tdata_o, 0);
    chk("rst_tid", m_tid_o, 0);
    chk("rst_done", atx_done, 0);
    chk("rst_atx_rdy", atx_rdy, 0);
    chk("rst_wdata_rdy", atx_wdata_rdy, 0);
    repeat (3) tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic push(int id, int len, int dest);
    int t = 0;
    atx_awid  = IW'(id);
    atx_awlen = LW'(len);
    atx_tdest = TW'(dest);
    atx_vld   = 1'b1;
    do begin
      tick();
      t++;
    end while (!push_seen && t < 50);
    atx_vld = 1'b0;
    chk("push_hs", push_seen, 1);
  endtask

  task automatic send(int n);
    int got = 0, t = 0;
    atx_wdata_vld = 1'b1;
    atx_wdata = rnd();
    while (got < n && t < n * 20 + 50) begin
      tick();
      t++;
      if (wd_seen) begin
        got++;
        atx_wdata = rnd();
      end
    end
    atx_wdata_vld = 1'b0;
    chk("send_cnt", got, n);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    chk("drained", exp_q.size(), 0);
    tick();
  endtask

  initial begin
    int np, t, plen[40], pid[40], pdst[40];
    int ids[5] = '{1, 3, 7, 9, 5};
    atx_id = '{5'd3, 5'd7, 5'd3, 5'd1};
    do_reset();
    // single transaction, len 3
    m_tready_i = 1'b1;
    done_pulses = 0;
    push(3, 3, 1);
    oc.delete();
    send(4);
    drain();
    chk("r19_beats", oc.size(), 4);
    chk("r19_done", done_pulses, 2);
    // fill FIFO without data, then stream four single-beat transactions
    push(1, 0, 0);
    push(3, 0, 1);
    push(7, 0, 2);
    push(9, 0, 3);
    chk("r20_full", atx_rdy, 0);
    oc.delete();
    send(4);
    drain();
    chk("r20_beats", oc.size(), 4);
    // downstream stall with a pending beat
    m_tready_i = 1'b0;
    push(7, 3, 2);
    send(1);
    atx_wdata_vld = 1'b1;
    atx_wdata = rnd();
    hold = m_tdata_o;
    repeat (5) begin
      tick();
      chk("r21_wrdy", atx_wdata_rdy, 0);
      chk("r21_hold", m_tdata_o, hold);
    end
    m_tready_i = 1'b1;
    send(3);
    drain();
    // back-to-back two-beat transactions
    push(1, 1, 0);
    push(3, 1, 1);
    oc.delete();
    send(4);
    drain();
    chk("r22_beats", oc.size(), 4);
    if (oc.size() == 4) chk("r22_nobubble", oc[3] - oc[0], 3);
    // maximum length
    push(5, 255, 3);
    oc.delete();
    send(256);
    drain();
    chk("r23_beats", oc.size(), 256);
    push(5, 0, 0);
    oc.delete();
    send(1);
    drain();
    chk("r23_after", oc.size(), 1);
    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      plen[i] = $urandom_range(0, 7);
      pid[i]  = ids[$urandom_range(0, 4)];
      pdst[i] = $urandom_range(0, 3);
    end
    rand_ready = 1;
    np = 0;
    t = 0;
    atx_wdata = rnd();
    while ((np < 40 || mq_id.size() != 0 || exp_q.size() != 0) && t < 5000) begin
      if (np < 40) begin
        atx_awid  = IW'(pid[np]);
        atx_awlen = LW'(plen[np]);
        atx_tdest = TW'(pdst[np]);
      end
      atx_vld = (np < 40) && ($urandom_range(0, 2) != 0);
      atx_wdata_vld = ($urandom_range(0, 3) != 0);
      tick();
      t++;
      if (push_seen) np++;
      if (wd_seen) atx_wdata = rnd();
    end
    atx_vld = 1'b0;
    atx_wdata_vld = 1'b0;
    rand_ready = 0;
    m_tready_i = 1'b1;
    drain();
    chk("rand_pushed", np, 40);
    chk("rand_empty", mq_id.size(), 0);
    // reset in the middle of a transaction
    push(3, 3, 1);
    send(2);
    do_reset();
    chk("r24_tvalid", m_tvalid_o, 0);
    chk("r24_wrdy", atx_wdata_rdy, 0);
    done_pulses = 0;
    push(3, 0, 2);
    oc.delete();
    send(1);
    drain();
    chk("r24_beats", oc.size(), 1);
    chk("r24_done", done_pulses, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adma_dm_dst_axis.md
ADMA_DM_DST_AXIS -- requirements
Module: adma_dm_dst_axis

Interface
REQ-001 SHALL have parameters: DMA_CHN_NUM, 4, number of DMA channels; ATX_DST_DATA_W, 256, data width; ATX_DST_BYTE_AMT, ATX_DST_DATA_W/8, byte lanes; DST_TDEST_W, 2, TDEST width; MST_ID_W, 5, ID width; ATX_LEN_W, 8, burst length width; ATX_NUM_OSTD, DMA_CHN_NUM, transaction-info FIFO depth (power of 2, >=2).
REQ-002 SHALL have ports: aclk  in  1  sole clock (rising edge); aresetn  in  1  reset, asynchronous, active-low.
REQ-003 atx_awid  in  MST_ID_W  transaction ID; atx_awlen  in  ATX_LEN_W  beats minus 1; atx_tdest  in  DST_TDEST_W  stream destination; atx_vld  in  1; atx_rdy  out  1  transaction-info handshake.
REQ-004 atx_wdata  in  ATX_DST_DATA_W; atx_wdata_vld  in  1; atx_wdata_rdy  out  1  write-data handshake from the DMA engine.
REQ-005 atx_id  in  MST_ID_W x DMA_CHN_NUM (unpacked [0:DMA_CHN_NUM-1])  per-channel ID; atx_done  out  1 x DMA_CHN_NUM  per-channel completion pulse; atx_dst_err  out  1 x DMA_CHN_NUM  per-channel error.
REQ-006 m_tid_o  out  MST_ID_W; m_tdest_o  out  DST_TDEST_W; m_tdata_o  out  ATX_DST_DATA_W; m_tkeep_o, m_tstrb_o  out  ATX_DST_BYTE_AMT; m_tlast_o, m_tvalid_o  out  1; m_tready_i  in  1  AXI-Stream master.

Function
REQ-007 SHALL hold accepted {awid, awlen, tdest} in an in-order FIFO of ATX_NUM_OSTD entries; push on atx_vld && atx_rdy; atx_rdy = FIFO not full (no same-cycle pop bypass when full).
REQ-008 SHALL keep a beat counter (ATX_LEN_W bits) for the FIFO head transaction, incremented on each write-data handshake, cleared on the last beat.
REQ-009 atx_wdata_rdy SHALL be FIFO-not-empty AND (m_tvalid_o == 0 OR m_tready_i == 1); never asserted while FIFO is empty.
REQ-010 On write-data handshake the output register SHALL load tdata = atx_wdata, tid = head awid, tdest = head tdest, tkeep = tstrb = all ones, tlast = (beat counter == head awlen), and set m_tvalid_o next cycle (latency 1 cycle).
REQ-011 Last beat (counter == awlen) handshake SHALL pop the FIFO head in that same cycle; push and pop in one cycle SHALL leave occupancy unchanged.
REQ-012 awlen = 0 SHALL give a single beat with tlast = 1; awlen = 2^ATX_LEN_W-1 SHALL give 2^ATX_LEN_W beats, counter must not wrap before tlast.
REQ-013 m_tvalid_o SHALL clear after m_tready_i handshake unless a new beat loads the same cycle (back-to-back, full throughput); output fields SHALL stay stable while m_tvalid_o && !m_tready_i.
REQ-014 atx_done[c] SHALL pulse exactly one cycle, registered, in the cycle after m_tvalid_o && m_tready_i && m_tlast_o with m_tid_o == atx_id[c]; all matching channels pulse.
REQ-015 atx_dst_err[c] SHALL be constant 0.
REQ-016 Consecutive transactions SHALL stream without bubble: first beat of next transaction accepted in cycle after previous last beat handshake when FIFO holds it.

Reset
REQ-017 While aresetn = 0: FIFO empty, pointers/counter 0, m_tvalid_o = 0, m_tlast_o = 0, atx_done = 0, atx_rdy = 0 during reset then 1 after, atx_wdata_rdy = 0; data fields reset to 0.
REQ-018 Reset mid-transaction SHALL discard all queued info and in-flight beats; no atx_done pulse for discarded transactions.

Verification
REQ-019 One txn id=3, len=3, tdest=1, m_tready_i=1 -> 4 beats, tlast on 4th only, tid=3, tdest=1, tkeep=all ones; atx_done[c] for atx_id[c]=3 one cycle later.
REQ-020 Push 4 txns (len 0) without data -> atx_rdy low after 4th; supply 4 data beats -> 4 tlast beats, IDs in push order, atx_rdy high after first pop.
REQ-021 m_tready_i held 0 for 5 cycles with tvalid high -> outputs stable, atx_wdata_rdy = 0; release -> no beat lost or duplicated.
REQ-022 Two txns len=1 back-to-back, m_tready_i=1 -> 4 consecutive tvalid cycles, no bubble, tlast on beats 2 and 4.
REQ-023 len=255 txn -> 256 beats, tlast on beat 256 only, then counter 0.
REQ-024 aresetn low after 2 of 4 beats -> tvalid 0, FIFO empty; post-reset fresh txn len=0 completes normally, no stale done.
